// File: rtl/freq_gen_pkg.sv
// Shared constants for the multi-channel programmable clock divider.
package freq_gen_pkg;

   localparam int unsigned DEF_CNT_W = 32;

   localparam logic MODE_SQUARE = 1'b0;
   localparam logic MODE_PULSE  = 1'b1;

endpackage

// File: rtl/freq_gen_ch.sv
// One divider channel: counter, active/pending divisor+mode, registered fout/tick.
// Retunes take effect only at terminal count so the output never shows a runt period.
module freq_gen_ch
   import freq_gen_pkg::*;
#(
   parameter int unsigned CNT_W        = DEF_CNT_W,
   parameter int unsigned DEFAULT_DIV  = 25000000,
   parameter logic        DEFAULT_MODE = MODE_SQUARE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_sel,
   input  logic [CNT_W-1:0] wr_div,
   input  logic             wr_mode,
   input  logic             en,
   input  logic             sync,
   output logic             fout,
   output logic             tick
);

   localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   logic [CNT_W-1:0] act_div, pend_div, cnt;
   logic             act_mode, pend_mode;

   logic [CNT_W-1:0] act_div_n, pend_div_n, cnt_n;
   logic             act_mode_n, pend_mode_n, fout_n, tick_n;

   logic             running, tc;
   logic [CNT_W-1:0] xfer_div;
   logic             xfer_mode;

   assign running   = en && (act_div != '0);
   assign tc        = running && (cnt == act_div - ONE);
   // A write landing on the terminal-count cycle goes straight to active.
   assign xfer_div  = wr_sel ? wr_div  : pend_div;
   assign xfer_mode = wr_sel ? wr_mode : pend_mode;

   always_comb begin
      act_div_n   = act_div;
      act_mode_n  = act_mode;
      pend_div_n  = pend_div;
      pend_mode_n = pend_mode;
      cnt_n       = cnt;
      fout_n      = fout;
      tick_n      = 1'b0;

      if (wr_sel) begin
         pend_div_n  = wr_div;
         pend_mode_n = wr_mode;
      end

      if (sync) begin
         cnt_n  = '0;
         fout_n = 1'b0;
      end else if (!running) begin
         // Stopped or disabled: pending flows to active every cycle.
         act_div_n  = pend_div;
         act_mode_n = pend_mode;
         if (act_div == '0) begin
            cnt_n  = '0;
            fout_n = 1'b0;
         end
      end else if (tc) begin
         cnt_n      = '0;
         tick_n     = 1'b1;
         act_div_n  = xfer_div;
         act_mode_n = xfer_mode;
         if (xfer_mode != act_mode) begin
            fout_n = 1'b0;
         end else if (xfer_mode == MODE_PULSE) begin
            fout_n = 1'b1;
         end else begin
            fout_n = ~fout;
         end
      end else if (cnt > act_div - ONE) begin
         cnt_n = '0;
      end else begin
         cnt_n = cnt + ONE;
         if (act_mode == MODE_PULSE) begin
            fout_n = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         act_div   <= RST_DIV;
         act_mode  <= DEFAULT_MODE;
         pend_div  <= RST_DIV;
         pend_mode <= DEFAULT_MODE;
         cnt       <= '0;
         fout      <= 1'b0;
         tick      <= 1'b0;
      end else begin
         act_div   <= act_div_n;
         act_mode  <= act_mode_n;
         pend_div  <= pend_div_n;
         pend_mode <= pend_mode_n;
         cnt       <= cnt_n;
         fout      <= fout_n;
         tick      <= tick_n;
      end
   end

endmodule

// File: rtl/freq_gen.sv
// Multi-channel programmable frequency generator: write decode and channel fan-out.
module freq_gen
   import freq_gen_pkg::*;
#(
   parameter int unsigned  NUM_CH       = 4,
   parameter int unsigned  CNT_W        = DEF_CNT_W,
   parameter int unsigned  DEFAULT_DIV  = 25000000,
   parameter logic         DEFAULT_MODE = MODE_SQUARE,
   localparam int unsigned CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [CH_W-1:0]   wr_ch,
   input  logic [CNT_W-1:0]  wr_div,
   input  logic              wr_mode,
   input  logic [NUM_CH-1:0] ch_en,
   input  logic              sync,
   output logic [NUM_CH-1:0] fout,
   output logic [NUM_CH-1:0] tick
);

   // Addresses at or beyond NUM_CH match no channel and are dropped.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic wr_sel;

      assign wr_sel = wr_en && (wr_ch == CH_W'(i));

      freq_gen_ch #(
         .CNT_W        (CNT_W),
         .DEFAULT_DIV  (DEFAULT_DIV),
         .DEFAULT_MODE (DEFAULT_MODE)
      ) u_ch (
         .clk     (clk),
         .rst     (rst),
         .wr_sel  (wr_sel),
         .wr_div  (wr_div),
         .wr_mode (wr_mode),
         .en      (ch_en[i]),
         .sync    (sync),
         .fout    (fout[i]),
         .tick    (tick[i])
      );
   end

endmodule

// File: tb/tb_freq_gen.sv
// Self-checking bench for freq_gen: vector table through a scoreboard queue.
module tb_freq_gen;

   localparam int unsigned NCH = 4;
   localparam int unsigned CW  = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic            wr_en;
   logic [1:0]      wr_ch;
   logic [CW-1:0]   wr_div;
   logic            wr_mode;
   logic [NCH-1:0]  ch_en;
   logic            sync;
   logic [NCH-1:0]  fout;
   logic [NCH-1:0]  tick;

   typedef struct {
      logic           rst;
      logic           wr_en;
      logic [1:0]     wr_ch;
      logic [CW-1:0]  wr_div;
      logic           wr_mode;
      logic [NCH-1:0] ch_en;
      logic           sync;
      logic [NCH-1:0] chk;
      logic [NCH-1:0] fout;
      logic [NCH-1:0] tick;
      string          name;
   } vec_t;

   typedef struct {
      logic [NCH-1:0] chk;
      logic [NCH-1:0] fout;
      logic [NCH-1:0] tick;
      string          name;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   freq_gen #(
      .NUM_CH       (NCH),
      .CNT_W        (CW),
      .DEFAULT_DIV  (5),
      .DEFAULT_MODE (1'b0)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_ch   (wr_ch),
      .wr_div  (wr_div),
      .wr_mode (wr_mode),
      .ch_en   (ch_en),
      .sync    (sync),
      .fout    (fout),
      .tick    (tick)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", sb.size());
      $fatal(1, "watchdog");
   end

   // Expected {fout,tick} k edges after a counter restart at 0 with fout=f0, square mode.
   function automatic logic [1:0] per(input int k, input int d, input logic f0);
      logic [1:0] r;
      r[1] = f0 ^ (((k / d) % 2) != 0);
      r[0] = (k > 0) && ((k % d) == 0);
      return r;
   endfunction

   function automatic vec_t mk(input string nm);
      vec_t v;
      v.rst = 1'b0; v.wr_en = 1'b0; v.wr_ch = '0; v.wr_div = '0; v.wr_mode = 1'b0;
      v.ch_en = '1; v.sync = 1'b0; v.chk = '0; v.fout = '0; v.tick = '0;
      v.name = nm;
      return v;
   endfunction

   function automatic vec_t rst_vec(input string nm);
      vec_t v;
      v = mk(nm);
      v.rst = 1'b1;
      v.chk = '1;
      return v;
   endfunction

   function automatic vec_t setx(input vec_t v, input int ch, input logic [1:0] ft);
      vec_t r;
      r = v;
      r.chk[ch]  = 1'b1;
      r.fout[ch] = ft[1];
      r.tick[ch] = ft[0];
      return r;
   endfunction

   function automatic vec_t wr(input vec_t v, input int ch, input int div, input logic mode);
      vec_t r;
      r = v;
      r.wr_en   = 1'b1;
      r.wr_ch   = 2'(ch);
      r.wr_div  = CW'(div);
      r.wr_mode = mode;
      return r;
   endfunction

   task automatic check_out();
      exp_t e;
      if (sb.size() == 0) begin
         n_assert++;
         n_fail++;
         $display("FAIL scoreboard_empty: no expectation queued for output fout=%b tick=%b", fout, tick);
         return;
      end
      e = sb.pop_front();
      n_assert++;
      if (((fout & e.chk) !== (e.fout & e.chk)) || ((tick & e.chk) !== (e.tick & e.chk))) begin
         n_fail++;
         $display("FAIL %s @%0t: got fout=%b tick=%b, required fout=%b tick=%b (channels %b)",
                  e.name, $time, fout & e.chk, tick & e.chk, e.fout & e.chk, e.tick & e.chk, e.chk);
      end
   endtask

   task automatic drive(input vec_t v);
      exp_t e;
      @(negedge clk);
      rst = v.rst; wr_en = v.wr_en; wr_ch = v.wr_ch; wr_div = v.wr_div;
      wr_mode = v.wr_mode; ch_en = v.ch_en; sync = v.sync;
      e.chk = v.chk; e.fout = v.fout; e.tick = v.tick; e.name = v.name;
      sb.push_back(e);
      @(posedge clk);
      #1;
      check_out();
   endtask

   initial begin
      vec_t v;
      rst = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_div = '0; wr_mode = 1'b0;
      ch_en = '0; sync = 1'b0;

      // Default divisor 5 on every channel.
      vecs.push_back(rst_vec("s1_reset"));
      for (int k = 1; k <= 20; k++) begin
         v = mk("s1_default_div5");
         for (int c = 0; c < 4; c++) v = setx(v, c, per(k, 5, 1'b0));
         vecs.push_back(v);
      end

      // Retune ch1 to 3 mid-period: takes effect at the div-5 terminal count.
      vecs.push_back(rst_vec("s2_reset"));
      for (int k = 1; k <= 20; k++) begin
         v = mk("s2_retune_ch1");
         if (k == 3) v = wr(v, 1, 3, 1'b0);
         for (int c = 0; c < 4; c++)
            v = setx(v, c, (c == 1 && k > 5) ? per(k - 5, 3, 1'b1) : per(k, 5, 1'b0));
         vecs.push_back(v);
      end

      // Stop ch2 with divisor 0, then restart it with divisor 2.
      vecs.push_back(rst_vec("s3_reset"));
      for (int k = 1; k <= 20; k++) begin
         v = mk("s3_stop_restart_ch2");
         if (k == 1)  v = wr(v, 2, 0, 1'b0);
         if (k == 10) v = wr(v, 2, 2, 1'b0);
         for (int c = 0; c < 4; c++) begin
            if (c != 2 || k <= 5) v = setx(v, c, per(k, 5, 1'b0));
            else if (k <= 11)     v = setx(v, c, 2'b00);
            else                  v = setx(v, c, per(k - 11, 2, 1'b0));
         end
         vecs.push_back(v);
      end

      // ch0 div 4, ch1 div 6, sync on a ch0 terminal count; common tick 12 later.
      vecs.push_back(rst_vec("s4_reset"));
      for (int k = 1; k <= 22; k++) begin
         v = mk("s4_sync");
         if (k == 1) v = wr(v, 0, 4, 1'b0);
         if (k == 2) v = wr(v, 1, 6, 1'b0);
         if (k == 9) v.sync = 1'b1;
         v = setx(v, 0, (k <= 5) ? per(k, 5, 1'b0) : (k <= 8) ? per(k - 5, 4, 1'b1) : per(k - 9, 4, 1'b0));
         v = setx(v, 1, (k <= 5) ? per(k, 5, 1'b0) : (k <= 8) ? per(k - 5, 6, 1'b1) : per(k - 9, 6, 1'b0));
         for (int c = 2; c < 4; c++)
            v = setx(v, c, (k <= 8) ? per(k, 5, 1'b0) : per(k - 9, 5, 1'b0));
         vecs.push_back(v);
      end

      // ch3 pulse mode div 1, pause via ch_en, then bypass write back to square div 2.
      vecs.push_back(rst_vec("s5_reset"));
      for (int k = 1; k <= 22; k++) begin
         v = mk("s5_pulse_ch3");
         if (k == 1)  v = wr(v, 3, 1, 1'b1);
         if (k == 18) v = wr(v, 3, 2, 1'b0);
         if (k >= 12 && k <= 15) v.ch_en = 4'b0111;
         for (int c = 0; c < 3; c++) v = setx(v, c, per(k, 5, 1'b0));
         if (k <= 4)       v = setx(v, 3, 2'b00);
         else if (k == 5)  v = setx(v, 3, 2'b01);
         else if (k <= 11) v = setx(v, 3, 2'b11);
         else if (k <= 15) v = setx(v, 3, 2'b10);
         else if (k <= 17) v = setx(v, 3, 2'b11);
         else if (k == 18) v = setx(v, 3, 2'b01);
         else              v = setx(v, 3, per(k - 18, 2, 1'b0));
         vecs.push_back(v);
      end

      // Reset mid-period with a concurrent write and sync: write lost, default restarts.
      vecs.push_back(rst_vec("s6_reset"));
      for (int k = 1; k <= 3; k++) begin
         v = mk("s6_pre_reset");
         for (int c = 0; c < 4; c++) v = setx(v, c, per(k, 5, 1'b0));
         vecs.push_back(v);
      end
      v = wr(rst_vec("s6_reset_dominates"), 0, 2, 1'b0);
      v.sync = 1'b1;
      vecs.push_back(v);
      for (int j = 1; j <= 12; j++) begin
         v = mk("s6_after_reset");
         for (int c = 0; c < 4; c++) v = setx(v, c, per(j, 5, 1'b0));
         vecs.push_back(v);
      end

      for (int i = 0; i < vecs.size(); i++) drive(vecs[i]);

      // Freeze ch0 mid-count with ch_en low, ch1 keeps running; ch0 resumes from count 2.
      drive(rst_vec("hs_reset"));
      for (int k = 1; k <= 2; k++) begin
         v = mk("hs_run");
         v = setx(v, 0, per(k, 5, 1'b0));
         v = setx(v, 1, per(k, 5, 1'b0));
         drive(v);
      end
      for (int k = 1; k <= 6; k++) begin
         v = mk("hs_frozen");
         v.ch_en = 4'b1110;
         v = setx(v, 0, 2'b00);
         v = setx(v, 1, per(2 + k, 5, 1'b0));
         drive(v);
      end
      for (int j = 1; j <= 4; j++) begin
         v = mk("hs_resume");
         v = setx(v, 0, per(2 + j, 5, 1'b0));
         v = setx(v, 1, per(8 + j, 5, 1'b0));
         drive(v);
      end

      if (sb.size() != 0) begin
         n_assert++;
         n_fail++;
         $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
